// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, addresses a combinational instruction ROM and buffers
// {pc, instruction} pairs in a small FIFO drained by decode through valid/ready.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IMEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [63:0]                  imem_address,
  input  logic [31:0]                  imem_instruction,
  input  logic                         redirect_valid,
  input  logic [63:0]                  redirect_pc,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [31:0]                  dec_instruction,
  output logic [63:0]                  dec_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count,
  output logic                         fetch_halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e          state_q;
  logic [63:0]     pc_q;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic [63:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic in_range, enq, deq;
  logic unused_rpc_low;

  // Word-aligned redirect targets only; the low bits are discarded.
  assign unused_rpc_low = ^redirect_pc[1:0];

  // The whole 4-byte word must lie inside the ROM to be fetched.
  assign in_range  = (pc_q + 64'd3) < 64'(IMEM_SIZE);
  assign enq       = (state_q == StFetch) && in_range && !redirect_valid &&
                     (count_q < CntW'(DEPTH));
  assign dec_valid = (count_q != '0);
  assign deq       = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect_valid) begin
      // Any handshake this cycle is dropped along with the rest of the FIFO.
      state_q <= StFetch;
      pc_q    <= {redirect_pc[63:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        tail_q <= tail_q + PtrW'(1);
        pc_q   <= pc_q + 64'd4;
      end
      if (deq) begin
        head_q <= head_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(enq) - CntW'(deq);
      if ((state_q == StFetch) && !in_range) begin
        state_q <= StHalt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      pc_mem[tail_q]  <= pc_q;
      ins_mem[tail_q] <= imem_instruction;
    end
  end

  assign imem_address    = pc_q;
  assign dec_pc          = dec_valid ? pc_mem[head_q] : 64'h0;
  assign dec_instruction = dec_valid ? ins_mem[head_q] : 32'h0;
  assign fq_count        = count_q;
  assign fetch_halted    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instruction;
  logic [63:0] dec_pc;
  logic [2:0]  fq_count;
  logic        fetch_halted;

  logic [31:0] rom [256];

  fetch_queue #(
    .DEPTH    (4),
    .IMEM_SIZE(1024),
    .RESET_PC (64'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instruction (dec_instruction),
    .dec_pc          (dec_pc),
    .fq_count        (fq_count),
    .fetch_halted    (fetch_halted)
  );

  always #5 clk = ~clk;

  assign imem_instruction = (imem_address < 64'd1024) ? rom[imem_address[9:2]] : 32'hDEAD_BEEF;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_halted;
  bit          model_ok = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom_at(input logic [63:0] a);
    return rom[a[9:2]];
  endfunction

  // Compare DUT outputs to the model, then advance the model across the coming edge.
  task automatic cycle(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
    bit in_range, do_enq, do_deq;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    #4;
    if (model_ok) begin
      chk("imem_address", imem_address, m_pc);
      chk("fq_count", 64'(fq_count), 64'(mq.size()));
      chk("dec_valid", 64'(dec_valid), 64'(mq.size() != 0));
      chk("dec_pc", dec_pc, (mq.size() != 0) ? mq[0].pc : 64'h0);
      chk("dec_instruction", 64'(dec_instruction),
          64'((mq.size() != 0) ? mq[0].ins : 32'h0));
      chk("fetch_halted", 64'(fetch_halted), 64'(m_halted));
    end
    if (rst) begin
      mq.delete();
      m_pc     = 64'h0;
      m_halted = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (rv) begin
        mq.delete();
        m_pc     = {rpc[63:2], 2'b00};
        m_halted = 1'b0;
      end else begin
        in_range = (m_pc + 64'd3) < 64'd1024;
        do_enq   = !m_halted && in_range && (mq.size() < 4);
        do_deq   = (mq.size() != 0) && rdy;
        if (do_deq) void'(mq.pop_front());
        if (do_enq) begin
          mq.push_back('{pc: m_pc, ins: rom_at(m_pc)});
          m_pc = m_pc + 64'd4;
        end
        if (!in_range) m_halted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] rpc;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    @(posedge clk); #1;

    // Reset then stream with decode always ready
    cycle(1, 0, 0, 1);
    chk("t1 count", 64'(fq_count), 64'd0);
    chk("t1 valid", 64'(dec_valid), 64'd0);
    chk("t1 addr", imem_address, 64'h0);
    chk("t1 halted", 64'(fetch_halted), 64'd0);
    cycle(0, 0, 0, 1);
    chk("t1 valid1", 64'(dec_valid), 64'd1);
    chk("t1 pc0", dec_pc, 64'h0);
    chk("t1 ins0", 64'(dec_instruction), 64'(rom[0]));
    chk("t1 addr4", imem_address, 64'h4);
    cycle(0, 0, 0, 1);
    chk("t1 addr8", imem_address, 64'h8);

    // Fill while stalled, then drain
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    chk("t2 full", 64'(fq_count), 64'd4);
    chk("t2 addr held", imem_address, 64'h10);
    chk("t2 head", dec_pc, 64'h0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 1);
      chk("t2 drain pc", dec_pc, 64'(4 * i));
    end

    // Simultaneous enqueue and dequeue at count 2
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t3 count2", 64'(fq_count), 64'd2);
    cycle(0, 0, 0, 1);
    chk("t3 count stays", 64'(fq_count), 64'd2);
    chk("t3 pc adv", dec_pc, 64'h4);

    // Redirect with count 3
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    chk("t4 count3", 64'(fq_count), 64'd3);
    cycle(0, 1, 64'h43, 1);
    chk("t4 flushed", 64'(fq_count), 64'd0);
    chk("t4 invalid", 64'(dec_valid), 64'd0);
    chk("t4 addr", imem_address, 64'h40);
    cycle(0, 0, 0, 0);
    chk("t4 head", dec_pc, 64'h40);

    // Redirect to the last ROM word, then halt, then redirect out of halt
    cycle(0, 1, 64'h3FC, 1);
    chk("t5 addr", imem_address, 64'h3FC);
    cycle(0, 0, 0, 0);
    chk("t5 end pc", imem_address, 64'h400);
    chk("t5 one entry", 64'(fq_count), 64'd1);
    cycle(0, 0, 0, 0);
    chk("t5 halted", 64'(fetch_halted), 64'd1);
    cycle(0, 0, 0, 0);
    chk("t5 no enq", 64'(fq_count), 64'd1);
    cycle(0, 1, 64'h0, 0);
    chk("t5 resumed", 64'(fetch_halted), 64'd0);

    // Reset while full and halted
    cycle(0, 1, 64'h3F0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    chk("t6 full", 64'(fq_count), 64'd4);
    chk("t6 halted", 64'(fetch_halted), 64'd1);
    cycle(1, 0, 0, 0);
    chk("t6 count", 64'(fq_count), 64'd0);
    chk("t6 pc", imem_address, 64'h0);
    chk("t6 halted0", 64'(fetch_halted), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1) == 1) rpc = 64'h3C0 + 64'($urandom_range(63));
      else rpc = 64'($urandom_range(1023));
      if ($urandom_range(9) == 0) rpc = {$urandom, $urandom};
      cycle($urandom_range(99) == 0, $urandom_range(19) == 0, rpc, $urandom_range(2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
